// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Add/subtract unit built from 4-bit carry-lookahead groups that are spread
//   across STAGES register stages. The carry, the operands that have not yet
//   been used and the partial sum travel together down the pipe, so every
//   bit of a result leaves in the same cycle. Valid/ready handshake on both
//   sides; the whole pipe freezes while the output is stalled.
//
// Parameters
//   WIDTH      operand width, multiple of 4 (4..64)
//   STAGES     register stages, >= 1, must divide WIDTH/4
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands valid          in_ready   operands accepted this cycle
//   a, b       operands                cin        carry in (ADC/SBB only)
//   op         00 ADD, 01 SUB, 10 ADC, 11 SBB
//   out_valid  result valid            out_ready  downstream accepts result
//   sum        result                  cout       carry out of the MSB
//   ovf        signed overflow         zero       sum == 0
//   neg        sum MSB                 pg, gg     whole-word propagate/generate
module pipelined_cla_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             pg,
  output logic             gg
);

  localparam int unsigned NS  = STAGES;
  localparam int unsigned NG  = WIDTH / 4;
  localparam int unsigned GPS = NG / NS;

  // Per-stage pipeline registers; index NS-1 is the output register.
  logic [WIDTH-1:0] r_a   [NS];
  logic [WIDTH-1:0] r_b   [NS];
  logic [WIDTH-1:0] r_sum [NS];
  logic             r_c   [NS];
  logic             r_pg  [NS];
  logic             r_gg  [NS];
  logic             r_v   [NS];
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;

  // Next-state values for each stage register.
  logic [WIDTH-1:0] w_na   [NS];
  logic [WIDTH-1:0] w_nb   [NS];
  logic [WIDTH-1:0] w_nsum [NS];
  logic             w_nc   [NS];
  logic             w_npg  [NS];
  logic             w_ngg  [NS];
  logic             w_nv   [NS];
  logic             w_ovf;
  logic             w_zero;
  logic             w_neg;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_eff;
  logic             w_stall;

  // Working values of the stage currently being evaluated.
  logic [WIDTH-1:0] w_la;
  logic [WIDTH-1:0] w_lb;
  logic [WIDTH-1:0] w_ls;
  logic             w_lc;
  logic             w_lpg;
  logic             w_lgg;
  logic             w_lv;
  logic [3:0]       w_p;
  logic [3:0]       w_g;
  logic [3:0]       w_gc;
  logic             w_gp;
  logic             w_ggrp;

  assign w_stall  = r_v[NS-1] & ~out_ready;
  assign in_ready = ~w_stall;

  always_comb begin
    w_b_eff = op[0] ? ~b : b;
    unique case (op)
      2'b00:   w_c_eff = 1'b0;
      2'b01:   w_c_eff = 1'b1;
      default: w_c_eff = cin;
    endcase

    w_la   = '0;
    w_lb   = '0;
    w_ls   = '0;
    w_lc   = 1'b0;
    w_lpg  = 1'b0;
    w_lgg  = 1'b0;
    w_lv   = 1'b0;
    w_p    = '0;
    w_g    = '0;
    w_gc   = '0;
    w_gp   = 1'b0;
    w_ggrp = 1'b0;

    for (int unsigned s = 0; s < NS; s++) begin
      int unsigned prv;
      prv = (s == 0) ? 0 : s - 1;
      if (s == 0) begin
        w_la  = a;
        w_lb  = w_b_eff;
        w_ls  = '0;
        w_lc  = w_c_eff;
        w_lpg = 1'b1;
        w_lgg = 1'b0;
        w_lv  = in_valid;
      end else begin
        w_la  = r_a[prv];
        w_lb  = r_b[prv];
        w_ls  = r_sum[prv];
        w_lc  = r_c[prv];
        w_lpg = r_pg[prv];
        w_lgg = r_gg[prv];
        w_lv  = r_v[prv];
      end

      // Groups owned by this stage; the carry ripples group to group.
      for (int unsigned g = s * GPS; g < (s + 1) * GPS; g++) begin
        w_p     = w_la[4*g +: 4] ^ w_lb[4*g +: 4];
        w_g     = w_la[4*g +: 4] & w_lb[4*g +: 4];
        w_gc[0] = w_lc;
        w_gc[1] = w_g[0] | (w_p[0] & w_lc);
        w_gc[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_lc);
        w_gc[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_lc);
        w_ls[4*g +: 4] = w_p ^ w_gc;
        w_gp    = &w_p;
        w_ggrp  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
        w_lc    = w_ggrp | (w_gp & w_lc);
        // Word-level PG/GG accumulate upward with no carry-in term.
        w_lpg   = w_lpg & w_gp;
        w_lgg   = w_ggrp | (w_gp & w_lgg);
      end

      w_na[s]   = w_la;
      w_nb[s]   = w_lb;
      w_nsum[s] = w_ls;
      w_nc[s]   = w_lc;
      w_npg[s]  = w_lpg;
      w_ngg[s]  = w_lgg;
      w_nv[s]   = w_lv;
    end

    w_zero = (w_nsum[NS-1] == '0);
    w_neg  = w_nsum[NS-1][WIDTH-1];
    w_ovf  = (w_na[NS-1][WIDTH-1] == w_nb[NS-1][WIDTH-1])
           & (w_nsum[NS-1][WIDTH-1] != w_na[NS-1][WIDTH-1]);
  end

  // Data registers load only behind a valid slot, so bubbles leave the
  // output holding its last result (or zeros after reset).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < NS; s++) begin
        r_v[s]   <= 1'b0;
        r_a[s]   <= '0;
        r_b[s]   <= '0;
        r_sum[s] <= '0;
        r_c[s]   <= 1'b0;
        r_pg[s]  <= 1'b0;
        r_gg[s]  <= 1'b0;
      end
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (!w_stall) begin
      for (int unsigned s = 0; s < NS; s++) begin
        r_v[s] <= w_nv[s];
        if (w_nv[s]) begin
          r_a[s]   <= w_na[s];
          r_b[s]   <= w_nb[s];
          r_sum[s] <= w_nsum[s];
          r_c[s]   <= w_nc[s];
          r_pg[s]  <= w_npg[s];
          r_gg[s]  <= w_ngg[s];
        end
      end
      if (w_nv[NS-1]) begin
        r_ovf  <= w_ovf;
        r_zero <= w_zero;
        r_neg  <= w_neg;
      end
    end
  end

  assign out_valid = r_v[NS-1];
  assign sum       = r_sum[NS-1];
  assign cout      = r_c[NS-1];
  assign pg        = r_pg[NS-1];
  assign gg        = r_gg[NS-1];
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign neg       = r_neg;

endmodule
